dcache_wb_controller: RTL and testbench
=======================================

Name: dcache_wb_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the pipeline MEM stage (the EX/MEM address, store data, MemRead/MemWrite) and a slow off-chip 256-bit data memory.
- Returns load data to MEM/WB and raises a stall that freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB while a miss is serviced.
- Replaces the single-cycle data memory in the MEM stage.

Parameters:
- LINES, 32, number of cache lines; index width = log2(LINES).
- TAG_W, 22, tag width; equals 32 - 5 - log2(LINES).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous and active-low
- p1_addr_i  in  32  byte address from EX/MEM ALU result; word aligned
- p1_data_i  in  32  store data from EX/MEM
- p1_MemRead_i  in  1  load request
- p1_MemWrite_i  in  1  store request
- p1_data_o  out  32  load data, combinational on hit
- p1_stall_o  out  1  pipeline stall request
- mem_data_i  in  256  refill line from memory
- mem_ack_i  in  1  one-cycle completion pulse from memory
- mem_data_o  out  256  victim line for write-back
- mem_addr_o  out  32  line address (bits [4:0] = 0)
- mem_enable_o  out  1  memory request valid
- mem_write_o  out  1  1 = write-back, 0 = refill read

Behaviour:
- Address split: offset [4:0], word select [4:2], index [4+log2(LINES):5], tag = upper TAG_W bits.
- Per-line state: valid, dirty, tag, 256-bit data.
- req = p1_MemRead_i | p1_MemWrite_i.
- hit = valid[idx] & (tag[idx] == addr tag).
- If MemRead and MemWrite are both asserted, the access is treated as a write.
- Reset (rst_i = 0, asynchronous):
  - All valid and dirty bits = 0; FSM = IDLE.
  - mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, p1_stall_o = 0.
  - Data and tag arrays are not reset.
- p1_stall_o = req & ~hit, combinational. It rises in the cycle of a missing request and stays high until the cycle in which the refilled line hits.
- p1_data_o = selected word of line[idx] whenever hit, else 0.
- Write hit: at the clock edge, write the word at [4:2] and set dirty = 1. No stall; zero extra latency.
- Read hit: zero latency, no state change.
- FSM states: IDLE, WRITEBACK, REFILL, DONE.
  - IDLE, req & ~hit & dirty[idx] -> WRITEBACK. Drive mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, idx, 5'b0}, mem_data_o = victim line.
  - IDLE, req & ~hit & ~dirty[idx] -> REFILL. Drive mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {req tag, idx, 5'b0}.
  - WRITEBACK: hold all memory outputs stable until mem_ack_i = 1, then -> REFILL issuing the read in the next cycle. Dirty bit is not cleared here.
  - REFILL: hold until mem_ack_i = 1. In that edge capture mem_data_i into line[idx], set tag, valid = 1, dirty = 0, deassert mem_enable_o -> DONE.
  - DONE: single cycle; the line now hits; stall drops and a pending store is written as a normal write hit -> IDLE.
- mem_enable_o is registered. It is high from the cycle after the miss is detected until the cycle after ack. Between WRITEBACK ack and REFILL there is exactly one cycle with mem_enable_o = 1, mem_write_o = 0 (no idle gap required).
- mem_ack_i outside WRITEBACK/REFILL is ignored.
- Request inputs must be held stable while p1_stall_o = 1; the pipeline guarantees this.
- Reset mid-miss aborts the transaction and returns to IDLE. The memory model is reset alongside.
- Miss latency with memory ack latency L cycles: clean miss = L + 2 stall cycles; dirty miss = 2L + 3 stall cycles.

Test Plan:
- Cold load: reset, load addr 0x0000_0040 with memory ack latency 10 and line word1 = 0xDEADBEEF at 0x44 loaded via addr 0x44 -> one refill read at mem_addr_o = 0x40, mem_write_o = 0, stall 12 cycles, p1_data_o = 0xDEADBEEF, no write-back.
- Hit path: after the above, load 0x48 -> p1_stall_o stays 0, data returned the same cycle, mem_enable_o stays 0.
- Store hit then conflict eviction: store 0x12345678 to 0x44, then load 0x0000_0444 (same index 2, different tag) -> write-back at addr 0x40 with word1 = 0x12345678 first, then refill at 0x440; stall = 23 cycles with L = 10.
- Write-allocate miss: store 0xA5A5A5A5 to clean-missing 0x800 -> refill read of 0x800, DONE writes the word, dirty = 1; a later load of 0x800 returns 0xA5A5A5A5 with no stall.
- Async reset during REFILL: pull rst_i low for 1 cycle mid-wait -> mem_enable_o = 0 immediately, stall = 0; re-access of the same address misses (valid cleared).
- Simultaneous MemRead and MemWrite, and a spurious mem_ack_i in IDLE -> treated as a write; no state change from the ack.

Source files
------------

// File: rtl/dcache_wb_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache for the MEM stage.
// A missing request stalls the pipeline while a dirty victim is written back and the line is refilled.
//
// state     | meaning
// IDLE      | serving hits, watching for a miss
// WRITEBACK | dirty victim line on the memory bus, waiting for ack
// REFILL    | line read issued, waiting for ack and refill data
// DONE      | refilled line hits; a pending store lands as a write hit
module dcache_wb_controller #(
  parameter int LINES = 32,
  parameter int TAG_W = 22
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  p1_addr_i,
  input  logic [31:0]  p1_data_i,
  input  logic         p1_MemRead_i,
  input  logic         p1_MemWrite_i,
  output logic [31:0]  p1_data_o,
  output logic         p1_stall_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,
  output logic [255:0] mem_data_o,
  output logic [31:0]  mem_addr_o,
  output logic         mem_enable_o,
  output logic         mem_write_o
);
  localparam int IDX_W = $clog2(LINES);

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, DONE} state_t;

  state_t             state_q, state_d;
  logic               mem_enable_q, mem_enable_d;
  logic               mem_write_q, mem_write_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [LINES-1:0]   dirty_q, dirty_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [255:0]       line_q [LINES];

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   req_tag;
  logic [7:0]         word_lsb;
  logic               req, hit, store_we, refill_we;
  logic [1:0]         unused_addr_bits;

  assign idx              = p1_addr_i[5 +: IDX_W];
  assign req_tag          = p1_addr_i[31 -: TAG_W];
  assign word_lsb         = {p1_addr_i[4:2], 5'b0};
  assign unused_addr_bits = p1_addr_i[1:0];

  assign req       = p1_MemRead_i | p1_MemWrite_i;
  assign hit       = valid_q[idx] && (tag_q[idx] == req_tag);
  // MemWrite wins when both strobes are high, so a write strobe alone decides stores
  assign store_we  = p1_MemWrite_i & hit;
  assign refill_we = (state_q == REFILL) & mem_ack_i;

  assign p1_stall_o   = rst_i & req & ~hit;
  assign p1_data_o    = hit ? line_q[idx][word_lsb +: 32] : 32'h0;
  assign mem_data_o   = line_q[idx];
  assign mem_addr_o   = mem_addr_q;
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (refill_we) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end
    if (store_we) dirty_d[idx] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          mem_enable_d = 1'b1;
          if (dirty_q[idx]) begin
            state_d     = WRITEBACK;
            mem_write_d = 1'b1;
            mem_addr_d  = {tag_q[idx], idx, 5'b0};
          end else begin
            state_d     = REFILL;
            mem_write_d = 1'b0;
            mem_addr_d  = {req_tag, idx, 5'b0};
          end
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          state_d     = REFILL;
          mem_write_d = 1'b0;
          mem_addr_d  = {req_tag, idx, 5'b0};
        end
      end
      REFILL: begin
        if (mem_ack_i) begin
          state_d      = DONE;
          mem_enable_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'h0;
      valid_q      <= '0;
      dirty_q      <= '0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
    end
  end

  // Tag and data storage carry no reset; valid bits qualify them
  always_ff @(posedge clk_i) begin
    if (refill_we) begin
      tag_q[idx]  <= req_tag;
      line_q[idx] <= mem_data_i;
    end else if (store_we) begin
      line_q[idx][word_lsb +: 32] <= p1_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_wb_controller.sv
// Directed bench for dcache_wb_controller with a fixed-latency 256-bit memory model.
module tb_dcache_wb_controller;
  localparam int L = 10;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [31:0]  p1_addr_i = 32'h0;
  logic [31:0]  p1_data_i = 32'h0;
  logic         p1_MemRead_i = 1'b0;
  logic         p1_MemWrite_i = 1'b0;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic         spur_ack = 1'b0;

  int total = 0;
  int bad = 0;

  logic         ack_m;
  logic [255:0] rdata_m;
  int           cnt_m;
  logic [255:0] mem_m [128];
  int           wb_cnt, rd_cnt;
  logic [31:0]  wb_addr, rd_addr;
  logic [255:0] wb_data;

  dcache_wb_controller dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o)
  );

  always #5 clk_i = ~clk_i;

  assign mem_data_i = rdata_m;
  assign mem_ack_i  = ack_m | spur_ack;

  // Memory: acks L cycles after a request is first seen, one-cycle pulse
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_m   <= 1'b0;
      cnt_m   <= 0;
      rdata_m <= '0;
      wb_cnt  <= 0;
      rd_cnt  <= 0;
      wb_addr <= 32'h0;
      rd_addr <= 32'h0;
      wb_data <= '0;
      for (int l = 0; l < 128; l++)
        for (int w = 0; w < 8; w++)
          mem_m[l][w*32 +: 32] <= 32'h1000_0000 | 32'(l*32 + w*4);
      mem_m[2][63:32] <= 32'hDEAD_BEEF;
    end else if (ack_m) begin
      ack_m <= 1'b0;
      cnt_m <= 0;
    end else if (mem_enable_o) begin
      if (cnt_m + 1 == L) begin
        ack_m <= 1'b1;
        cnt_m <= 0;
        if (mem_write_o) begin
          mem_m[mem_addr_o[11:5]] <= mem_data_o;
          wb_cnt  <= wb_cnt + 1;
          wb_addr <= mem_addr_o;
          wb_data <= mem_data_o;
        end else begin
          rdata_m <= mem_m[mem_addr_o[11:5]];
          rd_cnt  <= rd_cnt + 1;
          rd_addr <= mem_addr_o;
        end
      end else begin
        cnt_m <= cnt_m + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Presents a request and waits for the stall to drop; returns stall cycles and hit data/enable
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, output int stalls,
                           output logic [31:0] data, output logic en);
    @(negedge clk_i);
    p1_MemRead_i  = rd;
    p1_MemWrite_i = wr;
    p1_addr_i     = addr;
    p1_data_i     = wdata;
    #1;
    stalls = 0;
    while (p1_stall_o && stalls < 200) begin
      stalls++;
      @(negedge clk_i);
      #1;
    end
    chk("stall_timeout", 32'(stalls < 200), 32'd1);
    data = p1_data_o;
    en   = mem_enable_o;
    @(posedge clk_i);
    #1;
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        vecs [6];
  int          st, rd0, wb0;
  logic [31:0] d;
  logic        en;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h40, 32'h0,         32'h1000_0040};
    vecs[1] = '{1'b1, 1'b0, 32'h5C, 32'h0,         32'h1000_005C};
    vecs[2] = '{1'b0, 1'b1, 32'h44, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 32'h44, 32'h0,         32'h1234_5678};
    vecs[4] = '{1'b1, 1'b1, 32'h48, 32'hCAFE_F00D, 32'h1000_0048};
    vecs[5] = '{1'b1, 1'b0, 32'h48, 32'h0,         32'hCAFE_F00D};

    // Reset state with a request already pending
    p1_MemRead_i = 1'b1;
    p1_addr_i    = 32'h44;
    #13;
    chk("rst_enable", 32'(mem_enable_o), 32'd0);
    chk("rst_write",  32'(mem_write_o), 32'd0);
    chk("rst_addr",   mem_addr_o, 32'h0);
    chk("rst_stall",  32'(p1_stall_o), 32'd0);
    p1_MemRead_i = 1'b0;
    @(negedge clk_i);
    #2 rst_i = 1'b1;

    // Cold load
    do_access(1'b1, 1'b0, 32'h44, 32'h0, st, d, en);
    chk("cold_stalls",  32'(st), 32'(L + 2));
    chk("cold_data",    d, 32'hDEAD_BEEF);
    chk("cold_rd_cnt",  32'(rd_cnt), 32'd1);
    chk("cold_rd_addr", rd_addr, 32'h40);
    chk("cold_wb_cnt",  32'(wb_cnt), 32'd0);

    // Hit path
    rd0 = rd_cnt;
    do_access(1'b1, 1'b0, 32'h48, 32'h0, st, d, en);
    chk("hit_stalls", 32'(st), 32'd0);
    chk("hit_data",   d, 32'h1000_0048);
    chk("hit_enable", 32'(en), 32'd0);

    // Hits: loads, store, combined read+write
    for (int i = 0; i < 6; i++) begin
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, st, d, en);
      chk($sformatf("vec%0d_stalls", i), 32'(st), 32'd0);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      chk($sformatf("vec%0d_enable", i), 32'(en), 32'd0);
    end
    chk("hits_no_reads", 32'(rd_cnt - rd0), 32'd0);

    // Conflict eviction of the dirty line
    do_access(1'b1, 1'b0, 32'h444, 32'h0, st, d, en);
    chk("evict_stalls",  32'(st), 32'(2*L + 3));
    chk("evict_wb_cnt",  32'(wb_cnt), 32'd1);
    chk("evict_wb_addr", wb_addr, 32'h40);
    chk("evict_wb_w1",   wb_data[63:32], 32'h1234_5678);
    chk("evict_wb_w2",   wb_data[95:64], 32'hCAFE_F00D);
    chk("evict_rd_addr", rd_addr, 32'h440);
    chk("evict_data",    d, 32'h1000_0444);

    // Write-allocate miss, then prove the line went dirty by evicting it
    wb0 = wb_cnt;
    do_access(1'b0, 1'b1, 32'h800, 32'hA5A5_A5A5, st, d, en);
    chk("wa_stalls",  32'(st), 32'(L + 2));
    chk("wa_rd_addr", rd_addr, 32'h800);
    chk("wa_no_wb",   32'(wb_cnt - wb0), 32'd0);
    do_access(1'b1, 1'b0, 32'h800, 32'h0, st, d, en);
    chk("wa_hit_stalls", 32'(st), 32'd0);
    chk("wa_hit_data",   d, 32'hA5A5_A5A5);
    do_access(1'b1, 1'b0, 32'h000, 32'h0, st, d, en);
    chk("wa_evict_stalls",  32'(st), 32'(2*L + 3));
    chk("wa_evict_wb_addr", wb_addr, 32'h800);
    chk("wa_evict_wb_w0",   wb_data[31:0], 32'hA5A5_A5A5);
    chk("wa_evict_data",    d, 32'h1000_0000);

    // Spurious ack while idle must change nothing
    rd0 = rd_cnt;
    wb0 = wb_cnt;
    @(negedge clk_i);
    spur_ack = 1'b1;
    @(negedge clk_i);
    spur_ack = 1'b0;
    #1;
    chk("spur_enable", 32'(mem_enable_o), 32'd0);
    do_access(1'b1, 1'b0, 32'h448, 32'h0, st, d, en);
    chk("spur_hit_stalls", 32'(st), 32'd0);
    chk("spur_hit_data",   d, 32'h1000_0448);
    do_access(1'b1, 1'b0, 32'h000, 32'h0, st, d, en);
    chk("spur_hit0_stalls", 32'(st), 32'd0);
    chk("spur_no_mem", 32'(rd_cnt - rd0 + wb_cnt - wb0), 32'd0);

    // Reset in the middle of a refill
    @(negedge clk_i);
    p1_MemRead_i = 1'b1;
    p1_addr_i    = 32'h600;
    repeat (5) @(negedge clk_i);
    #1;
    chk("mid_enable", 32'(mem_enable_o), 32'd1);
    chk("mid_write",  32'(mem_write_o), 32'd0);
    chk("mid_addr",   mem_addr_o, 32'h600);
    chk("mid_stall",  32'(p1_stall_o), 32'd1);
    #1 rst_i = 1'b0;
    #1;
    chk("abort_enable", 32'(mem_enable_o), 32'd0);
    chk("abort_stall",  32'(p1_stall_o), 32'd0);
    p1_MemRead_i = 1'b0;
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    do_access(1'b1, 1'b0, 32'h600, 32'h0, st, d, en);
    chk("after_rst_stalls",  32'(st), 32'(L + 2));
    chk("after_rst_data",    d, 32'h1000_0600);
    chk("after_rst_rd_addr", rd_addr, 32'h600);
    do_access(1'b1, 1'b0, 32'h448, 32'h0, st, d, en);
    chk("after_rst_cold_stalls", 32'(st), 32'(L + 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
